// File: rtl/fp21_sum_reduce.sv
// FP21 streaming sum-reduction controller feeding an external pipelined adder.
// Pairs incoming beats and returning partial sums, recirculates them through
// the adder until one value is left, and routes zero operands around the
// adder through a tag line that matches the adder latency.

package fp21_pkg;
    localparam int EXP_W  = 7;
    localparam int FRAC_W = 13;

    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W-1:0] exp;
        logic [FRAC_W-1:0]       frac;
    } u_float;
endpackage

module fp21_sum_reduce
    import fp21_pkg::*;
#(
    // add_c for a pair registered on add_a/add_b at edge T is consumed at edge T+ADD_LAT
    parameter int ADD_LAT = 11
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  u_float in_data,
    input  logic   in_last,
    output logic   out_valid,
    input  logic   out_ready,
    output u_float out_data,
    output u_float add_a,
    output u_float add_b,
    input  u_float add_c
);

    localparam int CNT_W = $clog2(ADD_LAT + 1);
    localparam int TAIL  = ADD_LAT - 1;

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_DRAIN,
        ST_OUTPUT
    } state_t;

    state_t             state_q, state_d;
    logic               spare_full_q, spare_full_d;
    u_float             spare_val_q, spare_val_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [ADD_LAT-1:0] tag_byp_q, tag_byp_d;
    u_float [ADD_LAT-1:0] tag_val_q, tag_val_d;
    logic               out_valid_q, out_valid_d;
    u_float             out_data_q, out_data_d;
    u_float             add_a_q, add_a_d;
    u_float             add_b_q, add_b_d;

    logic   r_valid;
    u_float r_val;
    logic   accept;
    logic   src_valid;
    u_float src_val;
    logic   issue;
    logic   issue_byp;
    u_float issue_val;

    function automatic logic is_zero(input u_float x);
        return !x.frac[FRAC_W-1];
    endfunction

    assign in_ready  = rst_n && (state_q == ST_ACCEPT) && !r_valid;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;

    // Returning result: bypass value when tagged, else the adder output with zeros canonicalised
    always_comb begin
        r_valid = tag_vld_q[TAIL];
        r_val   = add_c;
        if (tag_byp_q[TAIL]) begin
            r_val = tag_val_q[TAIL];
        end else if (is_zero(add_c)) begin
            r_val = '0;
        end
    end

    // Pairing, issue/bypass, tag line shift, in-flight count and packet FSM
    always_comb begin
        state_d      = state_q;
        spare_full_d = spare_full_q;
        spare_val_d  = spare_val_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        issue_byp    = 1'b0;
        issue_val    = '0;

        accept    = in_valid && in_ready;
        src_valid = (state_q != ST_OUTPUT) && (r_valid || accept);
        src_val   = r_valid ? r_val : in_data;
        issue     = src_valid && spare_full_q;

        if (src_valid) begin
            if (spare_full_q) begin
                spare_full_d = 1'b0;
                spare_val_d  = '0;
                if (!is_zero(spare_val_q) && !is_zero(src_val)) begin
                    add_a_d = spare_val_q;
                    add_b_d = src_val;
                end else begin
                    issue_byp = 1'b1;
                    if (!is_zero(spare_val_q)) begin
                        issue_val = spare_val_q;
                    end else if (!is_zero(src_val)) begin
                        issue_val = src_val;
                    end
                end
            end else begin
                spare_full_d = 1'b1;
                spare_val_d  = src_val;
            end
        end

        for (int i = ADD_LAT - 1; i > 0; i--) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_byp_d[i] = tag_byp_q[i-1];
            tag_val_d[i] = tag_val_q[i-1];
        end
        tag_vld_d[0] = issue;
        tag_byp_d[0] = issue_byp;
        tag_val_d[0] = issue_val;

        if (issue && !r_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!issue && r_valid) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        case (state_q)
            ST_ACCEPT: begin
                if (accept && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((cnt_q == '0) && !r_valid && spare_full_q) begin
                    state_d      = ST_OUTPUT;
                    out_valid_d  = 1'b1;
                    out_data_d   = spare_val_q;
                    spare_full_d = 1'b0;
                    spare_val_d  = '0;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d     = ST_ACCEPT;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    // State registers with synchronous active-low reset; in-flight tags are dropped on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_ACCEPT;
            spare_full_q <= 1'b0;
            spare_val_q  <= '0;
            cnt_q        <= '0;
            tag_vld_q    <= '0;
            tag_byp_q    <= '0;
            tag_val_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            spare_full_q <= spare_full_d;
            spare_val_q  <= spare_val_d;
            cnt_q        <= cnt_d;
            tag_vld_q    <= tag_vld_d;
            tag_byp_q    <= tag_byp_d;
            tag_val_q    <= tag_val_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
        end
    end

endmodule

// File: tb/tb_fp21_sum_reduce.sv
// Testbench for fp21_sum_reduce: behavioural pipelined adder, table-driven
// packets, a mid-flight reset sequence and randomized packets checked
// against a plain arithmetic sum.

module tb_fp21_sum_reduce;
    import fp21_pkg::*;

    localparam int ADD_LAT = 11;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   in_valid = 1'b0;
    logic   in_last = 1'b0;
    logic   out_ready = 1'b0;
    u_float in_data = '0;
    logic   in_ready;
    logic   out_valid;
    u_float out_data;
    u_float add_a;
    u_float add_b;
    u_float add_c;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int issue_cnt = 0;
    logic chk_ops = 1'b0;

    typedef struct {
        int         n;
        real        v[8];
        logic [20:0] exp_bits;
        int         lat;
        int         hold;
        int         issues;
    } vec_t;

    vec_t vecs[6];
    u_float pipe[ADD_LAT-1];

    fp21_sum_reduce #(.ADD_LAT(ADD_LAT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .add_a(add_a),
        .add_b(add_b),
        .add_c(add_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real to_real(input u_float x);
        real m;
        int  e;
        m = real'(x.frac) / 4096.0;
        e = int'(x.exp);
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x.sign ? -m : m;
    endfunction

    function automatic u_float from_real(input real v);
        u_float r;
        real    m;
        int     e;
        r = '0;
        if (v == 0.0) return r;
        r.sign = (v < 0.0);
        m = (v < 0.0) ? -v : v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        r.exp  = 7'(e);
        r.frac = 13'($rtoi(m * 4096.0));
        return r;
    endfunction

    // Adder model: exact cancellation comes back with frac=0 but a nonzero exponent
    function automatic u_float fadd(input u_float a, input u_float b);
        real    s;
        u_float r;
        s = to_real(a) + to_real(b);
        if (s == 0.0) begin
            r = '0;
            r.exp = 7'sd3;
            return r;
        end
        return from_real(s);
    endfunction

    // Behavioural adder pipeline; result visible before edge T+ADD_LAT for operands registered at T
    always @(posedge clk) begin
        pipe[0] <= fadd(add_a, add_b);
        for (int k = 1; k < ADD_LAT - 1; k++) pipe[k] <= pipe[k-1];
    end
    assign add_c = pipe[ADD_LAT-2];

    // Count adder issues (real and bypassed) and arm the operand check for real adds
    always @(posedge clk) begin
        if (rst_n && dut.issue) issue_cnt <= issue_cnt + 1;
        chk_ops <= rst_n && dut.issue && !dut.issue_byp;
    end

    // Operands of a real add must never be zero
    always @(negedge clk) begin
        if (chk_ops) begin
            check("adder_a_nonzero", 64'(add_a.frac[12]), 64'd1);
            check("adder_b_nonzero", 64'(add_b.frac[12]), 64'd1);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input u_float beats[$], input bit last_on_end, input bit gaps,
                                  output int first_acc, output bit ok);
        int n;
        ok = 1'b1;
        first_acc = -1;
        for (int i = 0; i < beats.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = last_on_end && (i == beats.size() - 1);
            @(negedge clk);
            n = 0;
            while (!in_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                check("accept_timeout", 64'd0, 64'd1);
                ok = 1'b0;
                in_valid = 1'b0;
                in_last = 1'b0;
                return;
            end
            if (first_acc < 0) first_acc = cyc + 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_output(input string name, input u_float beats[$], input logic [20:0] exp_bits,
                                input int exp_lat, input int hold, input int exp_issues, input bit gaps);
        int first_acc;
        int out_edge;
        int n;
        int start_issues;
        bit ok;
        u_float held;
        start_issues = issue_cnt;
        apply_stimulus(beats, 1'b1, gaps, first_acc, ok);
        if (!ok) return;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check({name, "_out_timeout"}, 64'd0, 64'd1);
            return;
        end
        out_edge = cyc;
        check({name, "_data"}, 64'(out_data), 64'(exp_bits));
        if (exp_lat >= 0) check({name, "_latency"}, 64'(out_edge - first_acc), 64'(exp_lat));
        held = out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_data"}, 64'(out_data), 64'(held));
            check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_valid_cleared"}, 64'(out_valid), 64'd0);
        check({name, "_issues"}, 64'(issue_cnt - start_issues), 64'(exp_issues));
        check({name, "_cnt_idle"}, 64'(dut.cnt_q), 64'd0);
    endtask

    // Global time bound so the bench always ends on its own
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        u_float q[$];
        int     first_acc;
        bit     ok;
        real    s;
        int     v;
        int     n;

        vecs[0] = '{1, '{1.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0}, 21'h01000, 1, 5, 0};
        vecs[1] = '{2, '{1.0, 2.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0}, 21'h03800, 13, 0, 1};
        vecs[2] = '{8, '{1.0, 1.0, 1.0, 1.0, 1.0, 1.0, 1.0, 1.0}, 21'h07000, 41, 0, 7};
        vecs[3] = '{3, '{0.0, 5.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0}, 21'h05400, 24, 0, 2};
        vecs[4] = '{2, '{0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0}, 21'h00000, 13, 0, 1};
        vecs[5] = '{2, '{1.0, -1.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0}, 21'h00000, 13, 0, 1};

        rst_n = 1'b0;
        @(negedge clk);
        check("reset_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_add_a", 64'(add_a), 64'd0);
        check("reset_add_b", 64'(add_b), 64'd0);
        check("reset_cnt", 64'(dut.cnt_q), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            q = {};
            for (int j = 0; j < vecs[i].n; j++) q.push_back(from_real(vecs[i].v[j]));
            check_output($sformatf("vec%0d", i), q, vecs[i].exp_bits, vecs[i].lat,
                         vecs[i].hold, vecs[i].issues, 1'b0);
        end

        q = {};
        for (int j = 0; j < 6; j++) q.push_back(from_real(1.0));
        apply_stimulus(q, 1'b0, 1'b0, first_acc, ok);
        check("midflight_cnt", 64'(dut.cnt_q), 64'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("midflight_in_ready_in_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);
        check("post_reset_cnt", 64'(dut.cnt_q), 64'd0);
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        q = {};
        q.push_back(from_real(2.0));
        q.push_back(from_real(2.0));
        check_output("post_reset_pkt", q, 21'h05000, 13, 0, 1, 1'b0);

        for (int p = 0; p < 25; p++) begin
            n = $urandom_range(1, 8);
            q = {};
            s = 0.0;
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) v = 0;
                else v = int'($urandom_range(0, 16)) - 8;
                q.push_back(from_real(real'(v)));
                s = s + real'(v);
            end
            check_output($sformatf("rand%0d", p), q, 21'(from_real(s)), -1,
                         $urandom_range(0, 3), n - 1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
